// File: rtl/gry_updn_cntr.sv
// Gray-coded up/down counter with a binary state register; optional saturation via GRY_CNTR_SAT_EN.
// Latency: one cycle from any input to all outputs. Backpressure: none, a step is taken every enabled cycle.
module gry_updn_cntr #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] rst_val,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             en,
   input  logic             dir,
   output logic [WIDTH-1:0] gry_cnt,
   output logic [WIDTH-1:0] bin_cnt,
   output logic             wrap_p
);

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ZERO     = '0;
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b = g;
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [WIDTH-1:0] nxt;
   logic             wrap_nxt;

   always_comb begin
      nxt      = bin_cnt;
      wrap_nxt = 1'b0;
      if (clr) begin
         nxt = ZERO;
      end else if (ld) begin
         nxt = gray_to_bin(ld_val);
      end else if (en) begin
         if (dir) begin
            if (bin_cnt == ALL_ONES) begin
               wrap_nxt = 1'b1;
`ifdef GRY_CNTR_SAT_EN
               nxt = ALL_ONES;
`else
               nxt = ZERO;
`endif
            end else begin
               nxt = bin_cnt + ONE;
            end
         end else begin
            if (bin_cnt == ZERO) begin
               wrap_nxt = 1'b1;
`ifdef GRY_CNTR_SAT_EN
               nxt = ZERO;
`else
               nxt = ALL_ONES;
`endif
            end else begin
               nxt = bin_cnt - ONE;
            end
         end
      end
   end

   // Gray is re-encoded from the same next value so it never lags the binary output.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bin_cnt <= gray_to_bin(rst_val);
         gry_cnt <= rst_val;
         wrap_p  <= 1'b0;
      end else begin
         bin_cnt <= nxt;
         gry_cnt <= nxt ^ (nxt >> 1);
         wrap_p  <= wrap_nxt;
      end
   end

endmodule

// File: tb/tb_gry_updn_cntr.sv
// Randomized scoreboard bench for gry_updn_cntr at WIDTH=4; honours GRY_CNTR_SAT_EN when defined.
module tb_gry_updn_cntr;

   localparam int W    = 4;
   localparam int MAXV = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [W-1:0] rst_val = '0;
   logic         clr = 1'b0;
   logic         ld = 1'b0;
   logic [W-1:0] ld_val = '0;
   logic         en = 1'b0;
   logic         dir = 1'b0;
   logic [W-1:0] gry_cnt;
   logic [W-1:0] bin_cnt;
   logic         wrap_p;

   gry_updn_cntr #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rst_val (rst_val),
      .clr     (clr),
      .ld      (ld),
      .ld_val  (ld_val),
      .en      (en),
      .dir     (dir),
      .gry_cnt (gry_cnt),
      .bin_cnt (bin_cnt),
      .wrap_p  (wrap_p)
   );

   always #5 clk = ~clk;

   typedef struct {
      int gry;
      int bin;
      int wrap;
      bit step;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Model state: the values the DUT outputs should currently show.
   int   m_bin  = 0;
   int   m_wrap = 0;

   function automatic int to_gray(input int b);
      return b ^ (b >> 1);
   endfunction

   function automatic int from_gray(input int g);
      for (int v = 0; v <= MAXV; v++) begin
         if (to_gray(v) == g) return v;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and queue the result for the following rising edge.
   task automatic cyc(input bit r_n, input int rv, input bit c, input bit l, input int lv,
                      input bit e, input bit d);
      exp_t x;
      @(negedge clk);
      rst_n   = r_n;
      rst_val = rv[W-1:0];
      clr     = c;
      ld      = l;
      ld_val  = lv[W-1:0];
      en      = e;
      dir     = d;
      x.step  = 1'b0;
      m_wrap  = 0;
      if (!r_n) begin
         m_bin = from_gray(rv);
      end else if (c) begin
         m_bin = 0;
      end else if (l) begin
         m_bin = from_gray(lv);
      end else if (e) begin
         x.step = 1'b1;
         if (d) begin
            if (m_bin == MAXV) begin
               m_wrap = 1;
`ifndef GRY_CNTR_SAT_EN
               m_bin = 0;
`endif
            end else begin
               m_bin = m_bin + 1;
            end
         end else begin
            if (m_bin == 0) begin
               m_wrap = 1;
`ifndef GRY_CNTR_SAT_EN
               m_bin = MAXV;
`endif
            end else begin
               m_bin = m_bin - 1;
            end
         end
      end
      x.bin  = m_bin;
      x.gry  = to_gray(m_bin);
      x.wrap = m_wrap;
      exp_q.push_back(x);
   endtask

   // Monitor: outputs are valid every cycle once something has been issued.
   initial begin : monitor
      exp_t x;
      int   prev_gry;
      prev_gry = 0;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("gry_cnt", int'(gry_cnt), x.gry);
            chk("bin_cnt", int'(bin_cnt), x.bin);
            chk("wrap_p", int'(wrap_p), x.wrap);
            chk("bin_matches_gray", int'(bin_cnt), from_gray(int'(gry_cnt)));
            if (x.step && (int'(gry_cnt) != prev_gry))
               chk("gray_one_bit_step", $countones(int'(gry_cnt) ^ prev_gry), 1);
            prev_gry = int'(gry_cnt);
         end
      end
   end

   initial begin : stim
      int rv;
      // Reset load of Gray 0110 -> binary 4.
      cyc(1'b0, 6, 1'b0, 1'b0, 0, 1'b1, 1'b1);
      // Load binary 14, then count up through the wrap, then idle.
      cyc(1'b1, 0, 1'b0, 1'b1, to_gray(14), 1'b0, 1'b0);
      cyc(1'b1, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
      cyc(1'b1, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
      cyc(1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
      // Down from 0: wraps to 15, or holds at 0 when saturating.
      cyc(1'b1, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      cyc(1'b1, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      cyc(1'b1, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      // Priority clr > ld > en, then load alone.
      cyc(1'b1, 0, 1'b1, 1'b1, 7, 1'b1, 1'b1);
      cyc(1'b1, 0, 1'b0, 1'b1, 7, 1'b0, 1'b0);
      // Free run up then down with random enable.
      for (int i = 0; i < 40; i++) cyc(1'b1, 0, 1'b0, 1'b0, 0, 1'($urandom_range(0, 3) != 0), 1'b1);
      for (int i = 0; i < 40; i++) cyc(1'b1, 0, 1'b0, 1'b0, 0, 1'($urandom_range(0, 3) != 0), 1'b0);
      // Fully random traffic including occasional reset, clear and load.
      for (int i = 0; i < 150; i++) begin
         cyc(1'($urandom_range(0, 15) != 0), int'($urandom_range(0, MAXV)),
             1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 7) == 0),
             int'($urandom_range(0, MAXV)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      // Reset driven between edges mid-count must wait for the next rising edge.
      cyc(1'b1, 0, 1'b0, 1'b1, to_gray(9), 1'b0, 1'b0);
      cyc(1'b1, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
      cyc(1'b1, 0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
      rv = 13;
      @(posedge clk);
      #3;
      rst_n   = 1'b0;
      rst_val = rv[W-1:0];
      #1;
      chk("midcycle_rst_gry_hold", int'(gry_cnt), to_gray(m_bin));
      chk("midcycle_rst_bin_hold", int'(bin_cnt), m_bin);
      cyc(1'b0, rv, 1'b0, 1'b0, 0, 1'b1, 1'b1);
      cyc(1'b1, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
